// File: rtl/wb_mem_arbiter_pkg.sv
// Shared types and constants for the SerV memory arbiter slice.
package mem_pkg;

  localparam int         WADR_W_DEF = 14;
  localparam logic [3:0] SEL_WORD   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DBUS,
    S_IBUS,
    S_LOCAL,
    S_RELEASE
  } arb_state_t;

endpackage

// File: rtl/wb_mem_arbiter_ibuf_line.sv
// One-word instruction buffer: tag/data line with hit compare, fill and
// tag-matched invalidate.
module ibuf_line
  import mem_pkg::*;
#(
  parameter int TAG_W = WADR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_fill,
  input  logic [TAG_W-1:0] i_fillTag,
  input  logic [31:0]      i_fillData,
  input  logic             i_inval,
  input  logic [TAG_W-1:0] i_invalTag,
  input  logic [TAG_W-1:0] i_lookupTag,
  output logic             o_hit,
  output logic [31:0]      o_data
);

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data;

  // Fill and invalidate come from different arbiter states, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fillTag;
      r_data  <= i_fillData;
    end else if (i_inval && (r_tag == i_invalTag)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookupTag);
  assign o_data = r_data;

endmodule

// File: rtl/wb_mem_arbiter.sv
// Arbitrates SerV ibus/dbus onto one Wishbone SRAM slave, answers
// out-of-range accesses locally and caches the last fetched instruction word.
module wb_mem_arbiter
  import mem_pkg::*;
#(
  parameter int WADR_W  = WADR_W_DEF,
  parameter bit IBUF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cyc,
  input  logic [31:0]       i_adr,
  output logic [31:0]       i_rdt,
  output logic              i_ack,
  input  logic              d_cyc,
  input  logic [31:0]       d_adr,
  input  logic              d_we,
  input  logic [31:0]       d_dat,
  input  logic [3:0]        d_sel,
  output logic [31:0]       d_rdt,
  output logic              d_ack,
  output logic              s_cyc,
  output logic [WADR_W-1:0] s_adr,
  output logic              s_we,
  output logic [31:0]       s_dat,
  output logic [3:0]        s_sel,
  input  logic [31:0]       s_rdt,
  input  logic              s_ack
);

  arb_state_t        r_state, w_nextState;
  logic              r_pendI, w_nextPendI;
  logic              r_relHold, w_nextRelHold;
  logic              r_sCyc, w_nextSCyc;
  logic [WADR_W-1:0] r_sAdr, w_nextSAdr;
  logic              r_sWe, w_nextSWe;
  logic [31:0]       r_sDat, w_nextSDat;
  logic [3:0]        r_sSel, w_nextSSel;
  logic [31:0]       r_iRdt, w_nextIRdt;
  logic [31:0]       r_dRdt, w_nextDRdt;
  logic              r_iAck, w_nextIAck;
  logic              r_dAck, w_nextDAck;

  logic              w_dOut, w_iOut;
  logic [WADR_W-1:0] w_dWord, w_iWord;
  logic              w_hit, w_fill, w_inval;
  logic [31:0]       w_bufData;
  logic              w_unusedLsb;

  assign w_dOut      = |d_adr[31:WADR_W+2];
  assign w_iOut      = |i_adr[31:WADR_W+2];
  assign w_dWord     = d_adr[WADR_W+1:2];
  assign w_iWord     = i_adr[WADR_W+1:2];
  assign w_unusedLsb = ^{i_adr[1:0], d_adr[1:0]};

  generate
    if (IBUF_EN) begin : g_ibuf
      ibuf_line #(.TAG_W(WADR_W)) u_ibuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_fill      (w_fill),
        .i_fillTag   (r_sAdr),
        .i_fillData  (s_rdt),
        .i_inval     (w_inval),
        .i_invalTag  (w_dWord),
        .i_lookupTag (w_iWord),
        .o_hit       (w_hit),
        .o_data      (w_bufData)
      );
    end else begin : g_nobuf
      logic w_unusedBuf;
      assign w_unusedBuf = w_fill ^ w_inval;
      assign w_hit       = 1'b0;
      assign w_bufData   = '0;
    end
  endgenerate

  always_comb begin
    w_nextState   = r_state;
    w_nextPendI   = r_pendI;
    w_nextRelHold = r_relHold;
    w_nextSCyc    = r_sCyc;
    w_nextSAdr    = r_sAdr;
    w_nextSWe     = r_sWe;
    w_nextSDat    = r_sDat;
    w_nextSSel    = r_sSel;
    w_nextIRdt    = r_iRdt;
    w_nextDRdt    = r_dRdt;
    w_nextIAck    = 1'b0;
    w_nextDAck    = 1'b0;
    w_fill        = 1'b0;
    w_inval       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_nextRelHold = 1'b0;
        if (d_cyc) begin
          w_nextPendI = 1'b0;
          if (w_dOut) begin
            w_nextState = S_LOCAL;
            w_nextDRdt  = '0;
          end else begin
            w_nextState = S_DBUS;
            w_nextSCyc  = 1'b1;
            w_nextSAdr  = w_dWord;
            w_nextSWe   = d_we;
            w_nextSDat  = d_dat;
            w_nextSSel  = d_sel;
            w_inval     = d_we;
          end
        end else if (i_cyc) begin
          w_nextPendI = 1'b1;
          if (w_iOut || w_hit) begin
            w_nextState = S_LOCAL;
            w_nextIRdt  = w_iOut ? 32'h0 : w_bufData;
          end else begin
            w_nextState = S_IBUS;
            w_nextSCyc  = 1'b1;
            w_nextSAdr  = w_iWord;
            w_nextSWe   = 1'b0;
            w_nextSSel  = SEL_WORD;
          end
        end
      end
      S_DBUS, S_IBUS: begin
        if (s_ack) begin
          w_nextState = S_RELEASE;
          w_nextSCyc  = 1'b0;
          if (r_state == S_IBUS) begin
            w_nextIRdt = s_rdt;
            w_nextIAck = 1'b1;
            w_fill     = 1'b1;
          end else begin
            w_nextDRdt = s_rdt;
            w_nextDAck = 1'b1;
          end
        end
      end
      S_LOCAL: begin
        w_nextState = S_RELEASE;
        w_nextIAck  = r_pendI;
        w_nextDAck  = !r_pendI;
      end
      // Wait out the slave's lingering ack, then one more cycle so the
      // just-acked master's stale cyc is not taken as a new request.
      S_RELEASE: begin
        if (!s_ack) begin
          if (r_relHold) w_nextState = S_IDLE;
          else           w_nextRelHold = 1'b1;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pendI   <= 1'b0;
      r_relHold <= 1'b0;
      r_sCyc    <= 1'b0;
      r_sAdr    <= '0;
      r_sWe     <= 1'b0;
      r_sDat    <= '0;
      r_sSel    <= '0;
      r_iRdt    <= '0;
      r_dRdt    <= '0;
      r_iAck    <= 1'b0;
      r_dAck    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_pendI   <= w_nextPendI;
      r_relHold <= w_nextRelHold;
      r_sCyc    <= w_nextSCyc;
      r_sAdr    <= w_nextSAdr;
      r_sWe     <= w_nextSWe;
      r_sDat    <= w_nextSDat;
      r_sSel    <= w_nextSSel;
      r_iRdt    <= w_nextIRdt;
      r_dRdt    <= w_nextDRdt;
      r_iAck    <= w_nextIAck;
      r_dAck    <= w_nextDAck;
    end
  end

  assign s_cyc = r_sCyc;
  assign s_adr = r_sAdr;
  assign s_we  = r_sWe;
  assign s_dat = r_sDat;
  assign s_sel = r_sSel;
  assign i_rdt = r_iRdt;
  assign i_ack = r_iAck;
  assign d_rdt = r_dRdt;
  assign d_ack = r_dAck;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: timing-level reference model checked every cycle,
// plus directed transactions with literal expectations.
module tb_wb_mem_arbiter;

  localparam int          WADR_W    = 14;
  localparam logic [31:0] MEM_BYTES = 32'h0001_0000;
  localparam int          TIMEOUT   = 500;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_cyc = 1'b0;
  logic [31:0]       i_adr = '0;
  logic [31:0]       i_rdt;
  logic              i_ack;
  logic              d_cyc = 1'b0;
  logic [31:0]       d_adr = '0;
  logic              d_we = 1'b0;
  logic [31:0]       d_dat = '0;
  logic [3:0]        d_sel = '0;
  logic [31:0]       d_rdt;
  logic              d_ack;
  logic              s_cyc;
  logic [WADR_W-1:0] s_adr;
  logic              s_we;
  logic [31:0]       s_dat;
  logic [3:0]        s_sel;
  logic [31:0]       s_rdt = '0;
  logic              s_ack;

  int cmpCount = 0;
  int failCount = 0;

  wb_mem_arbiter #(.WADR_W(WADR_W), .IBUF_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cyc(i_cyc), .i_adr(i_adr), .i_rdt(i_rdt), .i_ack(i_ack),
    .d_cyc(d_cyc), .d_adr(d_adr), .d_we(d_we), .d_dat(d_dat), .d_sel(d_sel),
    .d_rdt(d_rdt), .d_ack(d_ack),
    .s_cyc(s_cyc), .s_adr(s_adr), .s_we(s_we), .s_dat(s_dat), .s_sel(s_sel),
    .s_rdt(s_rdt), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks after slaveLat cycles of s_cyc, drops ack one cycle after s_cyc falls.
  int slaveLat = 5;
  int slaveCnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack    <= 1'b0;
      slaveCnt <= 0;
    end else if (s_cyc) begin
      if (slaveCnt >= slaveLat) s_ack <= 1'b1;
      slaveCnt <= slaveCnt + 1;
    end else begin
      s_ack    <= 1'b0;
      slaveCnt <= 0;
    end
  end

  // Reference model, expressed as edge timings relative to the sampled request.
  int                edgeNo;
  logic              mIdle, mWaitSlave, mCool, mWhoI;
  int                mAckEdge, mLowEdge;
  logic [31:0]       mLocalRdt;
  logic              mValid;
  logic [WADR_W-1:0] mTag;
  logic [31:0]       mData;
  logic              expSCyc, expSWe, expIAck, expDAck;
  logic [WADR_W-1:0] expSAdr;
  logic [31:0]       expSDat, expIRdt, expDRdt;
  logic [3:0]        expSSel;

  always @(posedge clk) edgeNo <= edgeNo + 1;
  initial edgeNo = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mIdle <= 1'b1; mWaitSlave <= 1'b0; mCool <= 1'b0; mWhoI <= 1'b0;
      mAckEdge <= -1; mLowEdge <= -1; mLocalRdt <= '0;
      mValid <= 1'b0; mTag <= '0; mData <= '0;
      expSCyc <= 1'b0; expSWe <= 1'b0; expIAck <= 1'b0; expDAck <= 1'b0;
      expSAdr <= '0; expSDat <= '0; expSSel <= '0; expIRdt <= '0; expDRdt <= '0;
    end else begin
      expIAck <= 1'b0;
      expDAck <= 1'b0;
      if (mIdle) begin
        if (d_cyc) begin
          mIdle <= 1'b0; mWhoI <= 1'b0;
          if (d_adr >= MEM_BYTES) begin
            mAckEdge <= edgeNo + 1; mLocalRdt <= 32'h0;
          end else begin
            mWaitSlave <= 1'b1; expSCyc <= 1'b1;
            expSAdr <= WADR_W'(d_adr / 4); expSWe <= d_we;
            expSDat <= d_dat; expSSel <= d_sel;
            if (d_we && mTag == WADR_W'(d_adr / 4)) mValid <= 1'b0;
          end
        end else if (i_cyc) begin
          mIdle <= 1'b0; mWhoI <= 1'b1;
          if (i_adr >= MEM_BYTES) begin
            mAckEdge <= edgeNo + 1; mLocalRdt <= 32'h0;
          end else if (mValid && mTag == WADR_W'(i_adr / 4)) begin
            mAckEdge <= edgeNo + 1; mLocalRdt <= mData;
          end else begin
            mWaitSlave <= 1'b1; expSCyc <= 1'b1;
            expSAdr <= WADR_W'(i_adr / 4); expSWe <= 1'b0; expSSel <= 4'hF;
          end
        end
      end else if (mWaitSlave && s_ack) begin
        mWaitSlave <= 1'b0; mCool <= 1'b1; expSCyc <= 1'b0;
        if (mWhoI) begin
          expIAck <= 1'b1; expIRdt <= s_rdt;
          mValid <= 1'b1; mTag <= expSAdr; mData <= s_rdt;
        end else begin
          expDAck <= 1'b1; expDRdt <= s_rdt;
        end
      end else if (mAckEdge == edgeNo) begin
        mAckEdge <= -1; mCool <= 1'b1;
        if (mWhoI) begin expIAck <= 1'b1; expIRdt <= mLocalRdt; end
        else       begin expDAck <= 1'b1; expDRdt <= mLocalRdt; end
      end else if (mCool) begin
        if (!s_ack && mLowEdge < 0) mLowEdge <= edgeNo;
        else if (mLowEdge >= 0) begin
          mCool <= 1'b0; mLowEdge <= -1; mIdle <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    checkOutput("s_cyc", {31'b0, s_cyc}, {31'b0, expSCyc});
    checkOutput("i_ack", {31'b0, i_ack}, {31'b0, expIAck});
    checkOutput("d_ack", {31'b0, d_ack}, {31'b0, expDAck});
    if (expSCyc) begin
      checkOutput("s_adr", 32'(s_adr), 32'(expSAdr));
      checkOutput("s_we",  {31'b0, s_we}, {31'b0, expSWe});
      checkOutput("s_sel", {28'b0, s_sel}, {28'b0, expSSel});
      if (expSWe) checkOutput("s_dat", s_dat, expSDat);
    end
    if (expIAck) checkOutput("i_rdt", i_rdt, expIRdt);
    if (expDAck) checkOutput("d_rdt", d_rdt, expDRdt);
  end

  // Per-transaction measurements used by the literal checks.
  int          iAckCnt, dAckCnt, sCycCnt, iLat, dLat, minGap, riseCnt, lowRun;
  logic [31:0] lastIRdt, lastDRdt;
  logic [WADR_W-1:0] riseAdr [2];
  logic [3:0]  firstSel;
  logic        firstWe, timedOut;

  task automatic observe(input int n, input logic prevS);
    if (s_cyc) begin
      sCycCnt++;
      if (!prevS) begin
        if (riseCnt < 2) riseAdr[riseCnt] = s_adr;
        if (riseCnt == 0) begin firstSel = s_sel; firstWe = s_we; end
        if (riseCnt > 0 && lowRun < minGap) minGap = lowRun;
        riseCnt++;
      end
      lowRun = 0;
    end else begin
      lowRun++;
    end
    if (i_ack) begin
      iAckCnt++;
      if (iLat < 0) begin iLat = n; lastIRdt = i_rdt; end
    end
    if (d_ack) begin
      dAckCnt++;
      if (dLat < 0) begin dLat = n; lastDRdt = d_rdt; end
    end
  endtask

  task automatic applyStimulus(input logic ic, input logic [31:0] ia,
                               input logic dc, input logic [31:0] da, input logic dwe,
                               input logic [31:0] ddat, input logic [3:0] dsel,
                               input logic [31:0] srdt, input int lat);
    int   n;
    logic prevS;
    @(negedge clk);
    slaveLat = lat; s_rdt = srdt;
    i_cyc = ic; i_adr = ia;
    d_cyc = dc; d_adr = da; d_we = dwe; d_dat = ddat; d_sel = dsel;
    iAckCnt = 0; dAckCnt = 0; sCycCnt = 0; iLat = -1; dLat = -1;
    minGap = 1000; riseCnt = 0; lowRun = 0; riseAdr[0] = '0; riseAdr[1] = '0;
    firstSel = '0; firstWe = 1'b0; timedOut = 1'b0;
    n = 0; prevS = s_cyc;
    while ((i_cyc || d_cyc) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      observe(n, prevS);
      prevS = s_cyc;
      if (i_ack) i_cyc = 1'b0;
      if (d_ack) begin d_cyc = 1'b0; d_we = 1'b0; end
    end
    if (n >= TIMEOUT) timedOut = 1'b1;
    i_cyc = 1'b0; d_cyc = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n++;
      observe(n, prevS);
      prevS = s_cyc;
    end
    checkOutput("ackTimeout", {31'b0, timedOut}, 32'h0);
  endtask

  initial begin
    #1;
    checkOutput("rst_s_cyc", {31'b0, s_cyc}, 32'h0);
    checkOutput("rst_i_ack", {31'b0, i_ack}, 32'h0);
    checkOutput("rst_d_ack", {31'b0, d_ack}, 32'h0);
    checkOutput("rst_i_rdt", i_rdt, 32'h0);
    checkOutput("rst_d_rdt", d_rdt, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] ibus miss 0x10");
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 60);
    checkOutput("miss_s_adr", 32'(riseAdr[0]), 32'd4);
    checkOutput("miss_s_sel", {28'b0, firstSel}, 32'hF);
    checkOutput("miss_s_we", {31'b0, firstWe}, 32'h0);
    checkOutput("miss_i_rdt", lastIRdt, 32'hDEAD_BEEF);
    checkOutput("miss_ack_len", iAckCnt, 32'd1);

    $display("[TB] ibus hit 0x10");
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h5555_AAAA, 10);
    checkOutput("hit_s_cyc_cnt", sCycCnt, 32'd0);
    checkOutput("hit_latency", iLat, 32'd2);
    checkOutput("hit_i_rdt", lastIRdt, 32'hDEAD_BEEF);

    $display("[TB] dbus write 0x10 then ibus refetch");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h0000_1234, 4'b0011, 32'h0, 8);
    checkOutput("wr_s_we", {31'b0, firstWe}, 32'h1);
    checkOutput("wr_s_sel", {28'b0, firstSel}, 32'h3);
    checkOutput("wr_ack_len", dAckCnt, 32'd1);
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0000_1234, 8);
    checkOutput("inval_goes_to_slave", {31'b0, sCycCnt > 0}, 32'h1);
    checkOutput("inval_i_rdt", lastIRdt, 32'h0000_1234);

    $display("[TB] simultaneous dbus read 0x20 / ibus 0x30");
    applyStimulus(1'b1, 32'h30, 1'b1, 32'h20, 1'b0, 32'h0, 4'hF, 32'hCAFE_0020, 10);
    checkOutput("sim_first_adr", 32'(riseAdr[0]), 32'd8);
    checkOutput("sim_second_adr", 32'(riseAdr[1]), 32'd12);
    checkOutput("sim_dbus_first", {31'b0, (dLat >= 0) && (dLat < iLat)}, 32'h1);
    checkOutput("sim_gap_ge2", {31'b0, minGap >= 2}, 32'h1);

    $display("[TB] out-of-range accesses");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0001_0000, 1'b1, 32'h7777_7777, 4'hF, 32'h0, 5);
    checkOutput("oor_d_s_cyc_cnt", sCycCnt, 32'd0);
    checkOutput("oor_d_latency", dLat, 32'd2);
    applyStimulus(1'b1, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h9999_9999, 5);
    checkOutput("oor_i_s_cyc_cnt", sCycCnt, 32'd0);
    checkOutput("oor_i_rdt", lastIRdt, 32'h0);

    $display("[TB] reset during ibus wait");
    @(negedge clk);
    slaveLat = 60; i_adr = 32'h40; i_cyc = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_s_cyc", {31'b0, s_cyc}, 32'h0);
    checkOutput("rstmid_i_ack", {31'b0, i_ack}, 32'h0);
    i_cyc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 6);
    checkOutput("post_rst_miss", {31'b0, sCycCnt > 0}, 32'h1);
    checkOutput("post_rst_i_rdt", lastIRdt, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
